// File: rtl/mem_dump_ctrl_pkg.sv
// Shared definitions for the post-execution dmem dump controller: widths, enable levels, FSM encodings.
// Optional counter trailer is selected by the PERF_CNT_EN macro in mem_dump_ctrl.sv.
package mem_dump_ctrl_pkg;

  localparam int   DATA_W_DEF = 32;
  localparam int   PERF_W     = 32;
  localparam logic ENABLE_N   = 1'b0;
  localparam logic DISABLE_N  = 1'b1;

  typedef enum logic [2:0] {
    RUN  = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    PERF = 3'd3,
    DONE = 3'd4
  } state_e;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_dump_ctrl_perf_cnt.sv
// Four saturating 32-bit core status counters (cycles, load-use stalls, branch stalls, taken-path branches).
// Counting stops while freeze is high; cleared only by reset.
module mem_dump_ctrl_perf_cnt
  import mem_dump_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              stall,
  input  logic              lwstall,
  input  logic              branchstall,
  input  logic              bra_op,
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] lw_cnt,
  output logic [PERF_W-1:0] bb_cnt,
  output logic [PERF_W-1:0] ab_cnt
);

  logic [PERF_W-1:0] cycle_q, lw_q, bb_q, ab_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_q <= '0;
      lw_q    <= '0;
      bb_q    <= '0;
      ab_q    <= '0;
    end else if (!freeze) begin
      cycle_q <= sat_inc(cycle_q);
      if (lwstall)          lw_q <= sat_inc(lw_q);
      if (branchstall)      bb_q <= sat_inc(bb_q);
      if (!stall && bra_op) ab_q <= sat_inc(ab_q);
    end
  end

  assign cycle_cnt = cycle_q;
  assign lw_cnt    = lw_q;
  assign bb_cnt    = bb_q;
  assign ab_cnt    = ab_q;

endmodule

// File: rtl/mem_dump_ctrl.sv
// Halts the core on ecall, then streams dmem[DUMP_BASE +: DUMP_WORDS] over valid/ready, one word per 2 cycles max.
// Define PERF_CNT_EN to append the cycle/lw/bb/ab counter trailer after the last dmem word.
module mem_dump_ctrl
  import mem_dump_ctrl_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = 16,
  parameter int DUMP_BASE  = 0,
  parameter int DUMP_WORDS = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ecall,
  input  logic              stall,
  input  logic              lwstall,
  input  logic              branchstall,
  input  logic              bra_op,
  output logic              halt,
  output logic [ADDR_W-1:0] mem_a,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              dump_valid,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  input  logic              dump_ready,
  output logic              done
);

  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(DUMP_BASE);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DUMP_WORDS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;

`ifdef PERF_CNT_EN
  logic [1:0]        pidx_q, pidx_d;
  logic [PERF_W-1:0] cycle_cnt, lw_cnt, bb_cnt, ab_cnt;
  logic [DATA_W-1:0] perf_word;

  mem_dump_ctrl_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .freeze      (halt),
    .stall       (stall),
    .lwstall     (lwstall),
    .branchstall (branchstall),
    .bra_op      (bra_op),
    .cycle_cnt   (cycle_cnt),
    .lw_cnt      (lw_cnt),
    .bb_cnt      (bb_cnt),
    .ab_cnt      (ab_cnt)
  );

  always_comb begin
    perf_word = DATA_W'(cycle_cnt);
    case (pidx_q)
      2'd1:    perf_word = DATA_W'(lw_cnt);
      2'd2:    perf_word = DATA_W'(bb_cnt);
      2'd3:    perf_word = DATA_W'(ab_cnt);
      default: perf_word = DATA_W'(cycle_cnt);
    endcase
  end
`else
  logic unused_status;
  assign unused_status = ^{stall, lwstall, branchstall, bra_op};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      idx_q   <= '0;
      data_q  <= '0;
`ifdef PERF_CNT_EN
      pidx_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
`ifdef PERF_CNT_EN
      pidx_q  <= pidx_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
`ifdef PERF_CNT_EN
    pidx_d  = pidx_q;
`endif
    case (state_q)
      RUN: begin
        if (ecall) state_d = LOAD;
      end
      // dmem read is combinational off the registered index, so one cycle per word is spent here.
      LOAD: begin
        data_d  = mem_rd;
        state_d = SEND;
      end
      SEND: begin
        if (dump_ready) begin
          if (idx_q == LAST_IDX) begin
`ifdef PERF_CNT_EN
            state_d = PERF;
            pidx_d  = 2'd0;
`else
            state_d = DONE;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
`ifdef PERF_CNT_EN
      PERF: begin
        if (dump_ready) begin
          if (pidx_q == 2'd3) state_d = DONE;
          else                pidx_d  = pidx_q + 2'd1;
        end
      end
`endif
      default: state_d = state_q;
    endcase
  end

  assign mem_a = BASE_A + idx_q;
  assign halt  = (state_q != RUN);
  assign done  = (state_q == DONE);

`ifdef PERF_CNT_EN
  assign dump_valid = (state_q == SEND) || (state_q == PERF);
  assign dump_last  = (state_q == PERF) && (pidx_q == 2'd3);
  assign dump_data  = (state_q == PERF) ? perf_word : data_q;
`else
  assign dump_valid = (state_q == SEND);
  assign dump_last  = (state_q == SEND) && (idx_q == LAST_IDX);
  assign dump_data  = data_q;
`endif

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Scoreboard bench for mem_dump_ctrl: stimulus pushes expected words, a forked monitor pops on each handshake.
// Build with +define+PERF_CNT_EN to also exercise the counter trailer.
module tb_mem_dump_ctrl;

`ifdef PERF_CNT_EN
  localparam int NTRL = 4;
`else
  localparam int NTRL = 0;
`endif
  localparam int NW = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ecall, stall, lwstall, branchstall, bra_op;
  logic        halt, dump_valid, dump_last, dump_ready, done;
  logic [15:0] mem_a;
  logic [31:0] mem_rd, dump_data;

  logic        ecall_b, halt_b, dump_valid_b, dump_last_b, dump_ready_b, done_b;
  logic [15:0] mem_a_b;
  logic [31:0] mem_rd_b, dump_data_b;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {~a, a};
  endfunction

  assign mem_rd   = mem_word(mem_a);
  assign mem_rd_b = mem_word(mem_a_b);

  mem_dump_ctrl #(.DATA_W(32), .ADDR_W(16), .DUMP_BASE(0), .DUMP_WORDS(NW)) dut (
    .clk(clk), .rst_n(rst_n), .ecall(ecall), .stall(stall), .lwstall(lwstall),
    .branchstall(branchstall), .bra_op(bra_op), .halt(halt), .mem_a(mem_a),
    .mem_rd(mem_rd), .dump_valid(dump_valid), .dump_data(dump_data),
    .dump_last(dump_last), .dump_ready(dump_ready), .done(done)
  );

  mem_dump_ctrl #(.DATA_W(32), .ADDR_W(16), .DUMP_BASE(10), .DUMP_WORDS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .ecall(ecall_b), .stall(stall), .lwstall(lwstall),
    .branchstall(branchstall), .bra_op(bra_op), .halt(halt_b), .mem_a(mem_a_b),
    .mem_rd(mem_rd_b), .dump_valid(dump_valid_b), .dump_data(dump_data_b),
    .dump_last(dump_last_b), .dump_ready(dump_ready_b), .done(done_b)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_stream(input logic [31:0] cyc, input logic [31:0] lw,
                             input logic [31:0] bb, input logic [31:0] ab);
    exp_t e;
    for (int i = 0; i < NW; i++) begin
      e.d = mem_word(16'(i));
      e.l = (i == NW - 1) && (NTRL == 0);
      q.push_back(e);
    end
    if (NTRL != 0) begin
      e.l = 1'b0;
      e.d = cyc; q.push_back(e);
      e.d = lw;  q.push_back(e);
      e.d = bb;  q.push_back(e);
      e.d = ab;  e.l = 1'b1; q.push_back(e);
    end
  endtask

  task automatic monitor();
    exp_t        e;
    logic [31:0] hd;
    logic        hl;
    bit          stalled;
    stalled = 1'b0;
    hd = '0;
    hl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("valid_held", 32'(dump_valid), 32'd1);
          chk("data_held", dump_data, hd);
          chk("last_held", 32'(dump_last), 32'(hl));
        end
        stalled = 1'b0;
        if (dump_valid && dump_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_word", dump_data, 32'hDEAD_BEEF);
          end else begin
            e = q.pop_front();
            chk("stream_data", dump_data, e.d);
            chk("stream_last", 32'(dump_last), 32'(e.l));
          end
        end else if (dump_valid) begin
          stalled = 1'b1;
          hd = dump_data;
          hl = dump_last;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ecall = 1'b0; ecall_b = 1'b0;
    stall = 1'b0; lwstall = 1'b0; branchstall = 1'b0; bra_op = 1'b0;
    dump_ready = 1'b1; dump_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Edge i (1..n) after reset release samples these inputs; ecall lands on edge n.
  task automatic run_until_ecall(input int n, input bit pat);
    for (int i = 1; i <= n; i++) begin
      ecall       = (i == n);
      lwstall     = pat && (i >= 3 && i <= 5);
      branchstall = pat && (i == 10 || i == 11);
      bra_op      = pat && ((i >= 20 && i <= 23) || i == 25);
      stall       = pat && (i == 25 || i == 3);
      @(posedge clk);
      #1;
    end
    ecall = 1'b0; lwstall = 1'b0; branchstall = 1'b0; bra_op = 1'b0; stall = 1'b0;
  endtask

  task automatic wait_done(input int bound, input bit rnd, input int pulse_at);
    bit seen, pulsed;
    seen = 1'b0;
    pulsed = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      #1;
      ecall = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (rnd) dump_ready = 1'($urandom_range(0, 1));
      if (pulse_at > 0 && !pulsed && i >= pulse_at && dump_valid) begin
        ecall = 1'b1;
        pulsed = 1'b1;
      end
    end
    ecall = 1'b0;
    dump_ready = 1'b1;
    chk("done_reached", 32'(seen), 32'd1);
    chk("stream_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    fork
      monitor();
    join_none

    // Reset values, then ecall on edge 5 with sink always ready.
    do_reset();
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_valid", 32'(dump_valid), 32'd0);
    chk("rst_data", dump_data, 32'd0);
    chk("rst_last", 32'(dump_last), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_a", 32'(mem_a), 32'd0);
    chk("rst_mem_a_b", 32'(mem_a_b), 32'd10);
    push_stream(32'd5, 32'd0, 32'd0, 32'd0);
    run_until_ecall(5, 1'b0);
    chk("halt_k1", 32'(halt), 32'd1);
    chk("valid_k1", 32'(dump_valid), 32'd0);
    @(posedge clk); #1;
    chk("valid_k2", 32'(dump_valid), 32'd1);
    chk("data_k2", dump_data, mem_word(16'd0));
    repeat (398) @(posedge clk);
    #1;
    chk("w199_data", dump_data, mem_word(16'd199));
    chk("w199_last", 32'(dump_last), 32'(NTRL == 0));
    chk("w199_not_done", 32'(done), 32'd0);
    repeat (NTRL + 1) @(posedge clk);
    #1;
    chk("done_after_last", 32'(done), 32'd1);
    chk("done_valid_low", 32'(dump_valid), 32'd0);
    chk("done_halt", 32'(halt), 32'd1);
    chk("t1_drained", 32'(q.size()), 32'd0);

    // ecall held 10 cycles, random backpressure, extra ecall mid-stream.
    do_reset();
    push_stream(32'd3, 32'd0, 32'd0, 32'd0);
    run_until_ecall(3, 1'b0);
    ecall = 1'b1;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    ecall = 1'b0;
    wait_done(4000, 1'b1, 40);
    ecall = 1'b1;
    @(posedge clk); #1;
    ecall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("done_ignores_ecall", 32'(done), 32'd1);
    chk("done_no_valid", 32'(dump_valid), 32'd0);

    // Reset while word 50 is being offered, then a clean restart.
    do_reset();
    push_stream(32'd5, 32'd0, 32'd0, 32'd0);
    run_until_ecall(5, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (q.size() == NW + NTRL - 50 && dump_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_word50", 32'(found), 32'd1);
    chk("word50_data", dump_data, mem_word(16'd50));
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_halt", 32'(halt), 32'd0);
    chk("midrst_valid", 32'(dump_valid), 32'd0);
    chk("midrst_data", dump_data, 32'd0);
    chk("midrst_last", 32'(dump_last), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_stream(32'd7, 32'd0, 32'd0, 32'd0);
    run_until_ecall(7, 1'b0);
    wait_done(1000, 1'b0, 0);

    // Single-word window at base 10.
    do_reset();
    @(posedge clk); #1;
    ecall_b = 1'b1;
    @(posedge clk); #1;
    ecall_b = 1'b0;
    chk("b_halt", 32'(halt_b), 32'd1);
    chk("b_mem_a", 32'(mem_a_b), 32'd10);
    @(posedge clk); #1;
    chk("b_valid", 32'(dump_valid_b), 32'd1);
    chk("b_data", dump_data_b, mem_word(16'd10));
    chk("b_last", 32'(dump_last_b), 32'(NTRL == 0));
    repeat (NTRL + 1) @(posedge clk);
    #1;
    chk("b_done", 32'(done_b), 32'd1);
    chk("b_valid_off", 32'(dump_valid_b), 32'd0);

`ifdef PERF_CNT_EN
    // 40 RUN cycles: 3 lwstall, 2 branchstall, 4 unstalled branches; counters frozen afterwards.
    do_reset();
    push_stream(32'd40, 32'd3, 32'd2, 32'd4);
    run_until_ecall(40, 1'b1);
    lwstall = 1'b1;
    bra_op = 1'b1;
    wait_done(1000, 1'b0, 0);
    lwstall = 1'b0;
    bra_op = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
